// File: rtl/derr_scheduler.sv
// Per-macroblock UV diffusion-error sequencer: fetches top/left error words,
// kicks the quantizer and store unit, and owns the shared top-error RAM port.
module derr_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DERR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] mb_w,
  input  logic [ADDR_W-1:0] mb_h,
  input  logic              mb_valid,
  output logic              mb_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              quant_start,
  input  logic              quant_done,
  output logic [DERR_W-1:0] left_derr_o,
  output logic [DERR_W-1:0] top_derr_o,
  output logic              store_start,
  output logic [ADDR_W-1:0] store_x,
  input  logic              store_done,
  input  logic [DERR_W-1:0] store_left_derr,
  input  logic              store_wr_en,
  input  logic              store_wr_we,
  input  logic [ADDR_W-1:0] store_wr_addr,
  input  logic [DERR_W-1:0] store_wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DERR_W-1:0] ram_wdata,
  input  logic [DERR_W-1:0] ram_rdata,
  output logic              coll_err
);

  typedef enum logic [3:0] {
    IDLE, WAIT_MB, RD, RD_WAIT, QSTART, QWAIT, STORE, SWAIT, NEXT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] w_q, h_q, x, y;
  logic [DERR_W-1:0] left_reg, top_reg;
  logic              last_col, last_row, zero_dim, accept;

  assign last_col = (x == w_q - ADDR_W'(1));
  assign last_row = (y == h_q - ADDR_W'(1));
  assign zero_dim = (mb_w == '0) || (mb_h == '0);
  assign accept   = (state == IDLE) && frame_start && !zero_dim;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = WAIT_MB;
      WAIT_MB: if (mb_valid) state_n = (y != '0) ? RD : QSTART;
      RD:      state_n = RD_WAIT;
      RD_WAIT: state_n = QSTART;
      QSTART:  state_n = QWAIT;
      QWAIT:   if (quant_done) state_n = STORE;
      STORE:   state_n = SWAIT;
      SWAIT:   if (store_done) state_n = NEXT;
      NEXT:    state_n = (last_col && last_row) ? IDLE : WAIT_MB;
      default: state_n = IDLE;
    endcase
  end

  // Single RAM port: our own top read in RD, store unit only while in SWAIT.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == RD) begin
      ram_en   = 1'b1;
      ram_addr = x;
    end else if (state == SWAIT) begin
      ram_en    = store_wr_en;
      ram_we    = store_wr_we;
      ram_addr  = store_wr_addr;
      ram_wdata = store_wr_data;
    end
  end

  // Quantizer operands are only presented while it is working on them.
  assign left_derr_o = (state == QSTART || state == QWAIT) ? left_reg : '0;
  assign top_derr_o  = (state == QSTART || state == QWAIT) ? top_reg  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      h_q         <= '0;
      x           <= '0;
      y           <= '0;
      left_reg    <= '0;
      top_reg     <= '0;
      busy        <= 1'b0;
      mb_ack      <= 1'b0;
      frame_done  <= 1'b0;
      quant_start <= 1'b0;
      store_start <= 1'b0;
      store_x     <= '0;
      coll_err    <= 1'b0;
    end else begin
      quant_start <= (state_n == QSTART);
      store_start <= (state_n == STORE);
      store_x     <= (state_n == STORE) ? x : '0;
      mb_ack      <= (state == SWAIT) && store_done;
      frame_done  <= ((state == IDLE) && frame_start && zero_dim) ||
                     ((state == NEXT) && last_col && last_row);
      if (accept)
        busy <= 1'b1;
      else if ((state == NEXT) && last_col && last_row)
        busy <= 1'b0;
      if (store_wr_en && (state != SWAIT))
        coll_err <= 1'b1;
      case (state)
        IDLE: if (frame_start) begin
          w_q      <= mb_w;
          h_q      <= mb_h;
          x        <= '0;
          y        <= '0;
          left_reg <= '0;
        end
        WAIT_MB: if (mb_valid && (y == '0)) top_reg <= '0;
        RD_WAIT: top_reg <= ram_rdata;
        // Row end: the next row's first macroblock has no left neighbour.
        SWAIT: if (store_done) left_reg <= last_col ? '0 : store_left_derr;
        NEXT: begin
          if (last_col) begin
            x <= '0;
            y <= y + ADDR_W'(1);
          end else begin
            x <= x + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/derr_scheduler.md
Name: derr_scheduler

Overview:
Sequences per-macroblock UV diffusion-error handling across a frame in raster order (x, y).
- Fetches the top error word for column x from the shared top-error RAM, and supplies the left error word.
- Starts the quantizer, then starts the diffusion-error store unit.
- Owns the single RAM port and arbitrates it between its own read and the store unit's write.
- Sits between the macroblock feeder, the UV quantizer and the store unit.

Parameters:
ADDR_W, 10, RAM address / x coordinate width
DERR_W, 32, packed error word width (4 x signed 8-bit)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_start  in  1  pulse; latches mb_w/mb_h, begins frame
mb_w  in  ADDR_W  macroblocks per row
mb_h  in  ADDR_W  macroblock rows
mb_valid  in  1  level; next macroblock data available
mb_ack  out  1  pulse; current macroblock fully processed
busy  out  1  high from frame accept until frame_done
frame_done  out  1  pulse after last macroblock
quant_start  out  1  pulse to quantizer
quant_done  in  1  pulse from quantizer
left_derr_o  out  DERR_W  left errors to quantizer
top_derr_o  out  DERR_W  top errors to quantizer
store_start  out  1  pulse to store unit
store_x  out  ADDR_W  column for store unit
store_done  in  1  pulse from store unit
store_left_derr  in  DERR_W  left errors produced by store unit
store_wr_en  in  1  store unit RAM enable
store_wr_we  in  1  store unit RAM write enable
store_wr_addr  in  ADDR_W  store unit RAM address
store_wr_data  in  DERR_W  store unit RAM data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DERR_W  RAM write data
ram_rdata  in  DERR_W  RAM read data, 1-cycle latency
coll_err  out  1  sticky; store write seen outside SWAIT

Behaviour:
- Reset: all outputs 0; state IDLE; x, y, left_reg, top_reg cleared. Reset mid-frame aborts immediately, with no further pulses.
- IDLE: on frame_start, latch mb_w and mb_h, clear x, y and left_reg, then go to WAIT_MB. If mb_w==0 or mb_h==0, pulse frame_done next cycle and stay IDLE.
- IDLE: frame_start is ignored in all other states.
- WAIT_MB: on mb_valid, go to RD if y!=0; if y==0, set top_reg=0 and go to QSTART.
- RD: ram_en=1, ram_we=0, ram_addr=x for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: top_reg <= ram_rdata, then go to QSTART.
- QSTART: quant_start=1 for one cycle, then go to QWAIT.
  - left_derr_o=left_reg and top_derr_o=top_reg are held stable from QSTART until leaving QWAIT.
- QWAIT: on quant_done, go to STORE. quant_done in any other state is ignored.
- STORE: store_start=1 and store_x=x for one cycle, then go to SWAIT.
- SWAIT: RAM port mux selects store_wr_* combinationally (ram_en=store_wr_en, and so on).
  - On store_done: left_reg <= store_left_derr, or 0 if x==mb_w-1. Pulse mb_ack the next cycle and go to NEXT.
  - store_done and the store write may coincide; the write passes through in that cycle.
- Outside SWAIT: store_wr_* never reaches the RAM. A store_wr_en seen outside SWAIT sets coll_err, which clears only on rst.
- NEXT (1 cycle): if x==mb_w-1, set x=0 and y++; otherwise x++.
  - If the macroblock just finished was (mb_w-1, mb_h-1): pulse frame_done, drop busy, go to IDLE.
  - Otherwise go to WAIT_MB.
- Control pulses (quant_start, store_start, mb_ack, frame_done) are registered and last exactly 1 cycle. ram_* outputs are 0 whenever no owner drives them.
- Minimum per-macroblock latency, quantizer and store returning done immediately:
  - y==0: 6 cycles from mb_valid to mb_ack.
  - y>0: 8 cycles from mb_valid to mb_ack.
- x and y are unsigned ADDR_W wide; mb_w up to 2^ADDR_W-1.

Test Plan:
- 2x2 frame, instant done responders:
  - Expect 4 mb_ack, then 1 frame_done.
  - Row 0: no RAM reads.
  - Row 1: reads at addr 0 then 1.
  - busy high throughout.
- Row 0, mb_w=3: store_left_derr=0x01020304 at x=0 → left_derr_o=0x01020304 at x=1. At x=2, store_left_derr is discarded, so x=0 of the next row sees left 0.
- Preload RAM[1]=0xAABBCCDD, y=1, x=1 → top_derr_o=0xAABBCCDD at quant_start. A store write at addr 1 with 0x11223344 appears on ram_* in SWAIT only.
- store_wr_en pulse during QWAIT → coll_err=1; ram_en stays 0 that cycle; coll_err remains set after frame_done.
- frame_start with mb_w=0 → frame_done one cycle later, no quant_start. A frame_start while busy has no effect on mb_w/mb_h.
- rst asserted during QWAIT → all outputs 0 next cycle. A later quant_done yields no store_start. A new frame restarts at x=0, y=0.
